// File: rtl/am2910_stack_ctrl.sv
// Return-address stack controller: TOS in a register, deeper entries in an external synchronous RAM.
// Optional macro STK_REPLACE_EN turns op 00 into REPLACE (overwrite TOS); otherwise op 00 is NOP.
module am2910_stack_ctrl #(
  parameter int STACK_DEPTH = 5,
  parameter int AW          = 3,
  parameter int DW          = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [1:0]    op,
  input  logic [DW-1:0] push_data,
  output logic          op_ready,
  output logic [DW-1:0] tos,
  output logic [3:0]    depth,
  output logic          empty,
  output logic          full,
  output logic          err_ovf,
  output logic          err_udf,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_POP   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {IDLE, POP_WAIT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] tos_q, tos_d;
  logic [3:0]    depth_q, depth_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_din_c;
  logic [3:0]    depth_m1;
  logic [3:0]    depth_m2;

  assign depth_m1 = depth_q - 4'd1;
  assign depth_m2 = depth_q - 4'd2;

  always_comb begin
    state_d    = state_q;
    tos_d      = tos_q;
    depth_d    = depth_q;
    err_ovf_d  = err_ovf_q;
    err_udf_d  = err_udf_q;
    ram_we_c   = 1'b0;
    ram_addr_c = '0;
    ram_din_c  = '0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_PUSH: begin
              if (full_q) begin
                err_ovf_d = 1'b1;
              end else begin
                // Spill the old TOS into RAM slot depth-1 in the same cycle.
                if (depth_q != 4'd0) begin
                  ram_we_c   = 1'b1;
                  ram_addr_c = AW'(depth_m1);
                  ram_din_c  = tos_q;
                end
                tos_d   = push_data;
                depth_d = depth_q + 4'd1;
              end
            end
            OP_POP: begin
              if (empty_q) begin
                err_udf_d = 1'b1;
              end else if (depth_q == 4'd1) begin
                tos_d   = '0;
                depth_d = 4'd0;
              end else begin
                ram_addr_c = AW'(depth_m2);
                state_d    = POP_WAIT;
              end
            end
            OP_CLEAR: begin
              tos_d     = '0;
              depth_d   = 4'd0;
              err_ovf_d = 1'b0;
              err_udf_d = 1'b0;
            end
            default: begin
`ifdef STK_REPLACE_EN
              tos_d = push_data;
              if (depth_q == 4'd0) depth_d = 4'd1;
`endif
            end
          endcase
        end
      end
      POP_WAIT: begin
        // RAM read issued in the acceptance cycle is valid now.
        tos_d   = ram_dout;
        depth_d = depth_m1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    empty_d = (depth_d == 4'd0);
    full_d  = (depth_d == 4'(STACK_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tos_q     <= '0;
      depth_q   <= 4'd0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tos_q     <= tos_d;
      depth_q   <= depth_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  // RAM strobes are forced quiet while reset is asserted so a held request cannot write.
  assign op_ready = (state_q == IDLE);
  assign ram_we   = ram_we_c & ~rst;
  assign ram_addr = rst ? '0 : ram_addr_c;
  assign ram_din  = rst ? '0 : ram_din_c;
  assign tos      = tos_q;
  assign depth    = depth_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

endmodule
